// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the fetch/data memory-port arbiter.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   // fetch (IF) requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   // data (DM) requester
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [STRB_W-1:0] dm_wstrb;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;

   // single-ported memory
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   // status
   logic              err;

   // arbiter side
   modport slave (
      input  if_req, if_addr, if_flush,
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
      input  mem_ack, mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output dm_gnt, dm_rvalid, dm_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output err
   );

   // environment side: requesters plus memory model
   modport master (
      output if_req, if_addr, if_flush,
      output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
      output mem_ack, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  dm_gnt, dm_rvalid, dm_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (IF) and data (DM) requesters.
// DM has priority; a starvation counter forces an IF grant after STARVE_LIMIT
// back-to-back DM grants with a fetch waiting. One transaction in flight.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned STRB_W   = DATA_W / 8;
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t              state;
   logic [STARVE_W-1:0] starve_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                drop;
   logic                err_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [STRB_W-1:0]   mem_wstrb_q;

   logic starve_hit_c;
   logic dm_gnt_c;
   logic if_gnt_c;
   logic busy_c;
   logic timeout_c;
   logic done_c;
   logic dm_rvalid_c;
   logic if_rvalid_c;

   // IDLE arbitration: DM wins unless a waiting fetch has been starved long enough
   assign starve_hit_c = bus.if_req && (starve_cnt == STARVE_W'(STARVE_LIMIT));
   assign dm_gnt_c     = !reset && (state == IDLE) && bus.dm_req && !starve_hit_c;
   assign if_gnt_c     = !reset && (state == IDLE) && bus.if_req && !dm_gnt_c;

   // completion: memory ack, or the wait counter expiring on its last cycle
   assign busy_c      = (state == BUSY_I) || (state == BUSY_D);
   assign timeout_c   = !reset && busy_c && !bus.mem_ack &&
                        (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
   assign done_c      = !reset && busy_c && (bus.mem_ack || timeout_c);
   assign dm_rvalid_c = done_c && (state == BUSY_D);
   assign if_rvalid_c = done_c && (state == BUSY_I) && !drop && !bus.if_flush;

   // requester-side outputs; read data is zero unless a real load/fetch ack
   assign bus.dm_gnt    = dm_gnt_c;
   assign bus.if_gnt    = if_gnt_c;
   assign bus.dm_rvalid = dm_rvalid_c;
   assign bus.if_rvalid = if_rvalid_c;
   assign bus.dm_rdata  = (dm_rvalid_c && bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
   assign bus.if_rdata  = (if_rvalid_c && bus.mem_ack) ? bus.mem_rdata : '0;

   // memory-side and status outputs straight from registers
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wstrb = mem_wstrb_q;
   assign bus.err       = err_q;

   // state, payload capture, starvation/wait counters and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         starve_cnt  <= '0;
         wait_cnt    <= '0;
         drop        <= 1'b0;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               drop     <= 1'b0;
               if (dm_gnt_c) begin
                  state       <= BUSY_D;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= bus.dm_we;
                  mem_addr_q  <= bus.dm_addr;
                  mem_wdata_q <= bus.dm_wdata;
                  mem_wstrb_q <= bus.dm_wstrb;
                  if (!bus.if_req) begin
                     starve_cnt <= '0;
                  end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                     starve_cnt <= starve_cnt + STARVE_W'(1);
                  end
               end else if (if_gnt_c) begin
                  state       <= BUSY_I;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= bus.if_addr;
                  mem_wdata_q <= '0;
                  mem_wstrb_q <= '0;
                  starve_cnt  <= '0;
               end
            end
            BUSY_I, BUSY_D: begin
               if ((state == BUSY_I) && bus.if_flush) begin
                  drop <= 1'b1;
               end
               if (done_c) begin
                  state     <= IDLE;
                  mem_req_q <= 1'b0;
                  drop      <= 1'b0;
                  if (timeout_c) begin
                     err_q <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            default: begin
               state     <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end
endmodule
